// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shift_pkg;

    // Operation select as presented on the mode port.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,   // logical left, zero fill
        SH_SRL = 2'b01,   // logical right, zero fill
        SH_SRA = 2'b10,   // arithmetic right, sign fill
        SH_ROR = 2'b11    // rotate right
    } shift_mode_t;

    // Handshake/iteration state of the unit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_stage.sv
// One log-shifter stage: moves the value by 2^k positions in the selected
// mode when enabled, otherwise passes it through untouched.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] k,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] sll_c [SHAMT_W];
    logic [WIDTH-1:0] srl_c [SHAMT_W];
    logic [WIDTH-1:0] sra_c [SHAMT_W];
    logic [WIDTH-1:0] ror_c [SHAMT_W];

    // Fixed-distance candidates for every stage; the distance is always at
    // most WIDTH/2, so every slice below is non-empty.
    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_cand
            localparam int S = 1 << gi;
            assign sll_c[gi] = {value[WIDTH-S-1:0], {S{1'b0}}};
            assign srl_c[gi] = {{S{1'b0}}, value[WIDTH-1:S]};
            assign sra_c[gi] = {{S{value[WIDTH-1]}}, value[WIDTH-1:S]};
            assign ror_c[gi] = {value[S-1:0], value[WIDTH-1:S]};
        end
    endgenerate

    // Pick the candidate for stage k and mode, or hold when the bit is clear.
    always_comb begin
        result = value;
        if (en) begin
            for (int i = 0; i < SHAMT_W; i++) begin
                if (k == SHAMT_W'(i)) begin
                    case (mode)
                        SH_SLL:  result = sll_c[i];
                        SH_SRL:  result = srl_c[i];
                        SH_SRA:  result = sra_c[i];
                        default: result = ror_c[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: accepts an operand, walks one shift-amount bit per
// clock through a single log-stage, then holds the result until taken.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               zero_out
);

    localparam logic [SHAMT_W-1:0] LAST_K = SHAMT_W'(SHAMT_W - 1);

    shift_state_t       state_reg, state_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic [SHAMT_W-1:0] shamt_reg, shamt_next;
    shift_mode_t        mode_reg, mode_next;

    logic               stage_en;
    logic [WIDTH-1:0]   stage_result;

    // Enable for the current stage is the latched shift-amount bit at k.
    always_comb begin
        stage_en = 1'b0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (cnt_reg == SHAMT_W'(i)) begin
                stage_en = shamt_reg[i];
            end
        end
    end

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .value  (work_reg),
        .k      (cnt_reg),
        .en     (stage_en),
        .mode   (mode_reg),
        .result (stage_result)
    );

    // State, work register and latched request; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            shamt_reg <= '0;
            mode_reg  <= SH_SLL;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            shamt_reg <= shamt_next;
            mode_reg  <= mode_next;
        end
    end

    // Next-state logic; flush wins over everything, including a new request.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        shamt_next = shamt_reg;
        mode_next  = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    work_next  = data_in;
                    shamt_next = shamt;
                    mode_next  = shift_mode_t'(mode);
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_next = stage_result;
                if (cnt_reg == LAST_K) begin
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    // Result is exposed only in DONE so partial work never leaks out.
    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
        data_out  = out_valid ? work_reg : '0;
        zero_out  = out_valid && (work_reg == '0);
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: 16-bit instance for the main checks and
// a 32-bit instance for the width-scaling case.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        in_valid, in_ready, out_valid, out_ready, zero_out;
    logic [15:0] data_in, data_out;
    logic [3:0]  shamt;
    logic [1:0]  mode;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, zero_out32;
    logic [31:0] data_in32, data_out32;
    logic [4:0]  shamt32;
    logic [1:0]  mode32;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    logic seen_valid;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shamt(shamt), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .zero_out(zero_out)
    );

    shift_unit_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .data_in(data_in32), .shamt(shamt32), .mode(mode32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .data_out(data_out32), .zero_out(zero_out32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request with out_ready high, scramble the inputs after the
    // accepting edge, then check latency, result, zero flag and handoff.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] s,
                          input logic [1:0] m, input logic [15:0] exp);
        @(negedge clk);
        data_in   = d;
        shamt     = s;
        mode      = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, " in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = ~d;
        shamt    = ~s;
        mode     = ~m;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, 4);
        chk({tag, " data"}, data_out, exp);
        chk({tag, " zero"}, zero_out, (exp == 16'h0000));
        @(posedge clk); #1;
        chk({tag, " handoff"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; data_in = '0; shamt = '0; mode = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; data_in32 = '0; shamt32 = '0; mode32 = '0;

        // Reset state
        #2;
        chk("reset outputs", {out_valid, zero_out, data_out}, 18'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1'b1);

        // Main function across all modes
        run_op("sll15",   16'h0001, 4'd15, SH_SLL, 16'h8000);
        run_op("sra3",    16'h8000, 4'd3,  SH_SRA, 16'hF000);
        run_op("srl3",    16'h8000, 4'd3,  SH_SRL, 16'h1000);
        run_op("sra4pos", 16'h7FF0, 4'd4,  SH_SRA, 16'h07FF);
        run_op("sra15",   16'h8001, 4'd15, SH_SRA, 16'hFFFF);
        run_op("ror4",    16'h1234, 4'd4,  SH_ROR, 16'h4123);
        run_op("ror0",    16'h1234, 4'd0,  SH_ROR, 16'h1234);
        run_op("ror12",   16'h1234, 4'd12, SH_ROR, 16'h2341);
        run_op("ror1wrap",16'h0001, 4'd1,  SH_ROR, 16'h8000);
        run_op("sll8zero",16'h0100, 4'd8,  SH_SLL, 16'h0000);

        // Backpressure: result held, no accept while DONE or on the handoff edge
        @(negedge clk);
        data_in = 16'h00F0; shamt = 4'd4; mode = SH_SRL;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        data_in = 16'hFFFF; shamt = 4'd0; mode = SH_SLL;
        repeat (4) begin @(posedge clk); #1; end
        chk("bp first valid", {out_valid, data_out}, {1'b1, 16'h000F});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp hold", {out_valid, in_ready, data_out, zero_out}, {2'b10, 16'h000F, 1'b0});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp handoff", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp no accept", in_ready, 1'b1);

        // Flush on the third SHIFT edge, also beating a pending request
        @(negedge clk);
        data_in = 16'h00FF; shamt = 4'd1; mode = SH_SLL; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush accepted", in_ready, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("flush idle", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        chk("flush beats valid", in_ready, 1'b1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        seen_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen_valid = seen_valid | out_valid; end
        chk("flush no result", seen_valid, 1'b0);

        // Asynchronous reset while a result is waiting in DONE
        @(negedge clk);
        data_in = 16'h00AA; shamt = 4'd0; mode = SH_SLL; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("pre-reset done", {out_valid, data_out}, {1'b1, 16'h00AA});
        #2;
        rst = 1'b1;
        #1;
        chk("async reset", {out_valid, zero_out, data_out}, 18'h0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("post-reset ready", {in_ready, out_valid}, 2'b10);

        // 32-bit instance: latency grows to 5
        @(negedge clk);
        data_in32 = 32'h1; shamt32 = 5'd31; mode32 = SH_SLL; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        cyc = 0;
        while (out_valid32 !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w32 latency", cyc, 5);
        chk("w32 data", data_out32, 32'h8000_0000);
        chk("w32 zero", zero_out32, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
